spi_ram_ctrl: RTL and testbench

- Consumes the 10-bit command words produced by the SPI slave and serves as that slave's memory back end.
- Decodes rx_data[9:8] into write-address, write-data, read-address and read-data commands, and holds a synchronous single-port RAM.
- Returns read bytes to the slave on tx_data/tx_valid for serialisation onto MISO.

---
 rtl/spi_ram_ctrl_pkg.sv | 24 ++
 rtl/spi_ram_ctrl_if.sv | 29 ++
 rtl/spi_ram_ctrl_mem.sv | 42 ++++
 rtl/spi_ram_ctrl.sv | 114 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg : shared types and constants for the SPI RAM back end.
//   - command opcodes carried in rx_data[9:8]
//   - command-word width and default address width
//   - tx path FSM states
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam int CMD_W        = 10;
    localparam int ADDR_SIZE_DEF = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_ram_if : command/response bundle between the SPI slave and its RAM
// back end.
//   rx_data  [CMD_W-1:0]  command word, [9:8]=opcode, [7:0]=address/data
//   rx_valid              command level from the SPI slave
//   tx_data  [7:0]        read byte returned to the slave
//   tx_valid              tx_data is valid
//   cmd_err               one-cycle pulse on a protocol-order violation
// Modports: slave = RAM controller side, master = SPI slave / bench side.
// ---------------------------------------------------------------------------
interface spi_ram_if #(parameter int CMD_W = spi_pkg::CMD_W);

    logic [CMD_W-1:0] rx_data;
    logic             rx_valid;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             cmd_err;

    modport slave (
        input  rx_data, rx_valid,
        output tx_data, tx_valid, cmd_err
    );

    modport master (
        output rx_data, rx_valid,
        input  tx_data, tx_valid, cmd_err
    );

endinterface

// File: rtl/spi_ram_ctrl_mem.sv
// ---------------------------------------------------------------------------
// spi_ram_mem : MEM_DEPTH x 8 synchronous single-port RAM with a registered
// read output. Only the output register is reset; contents are not.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (output register only)
//   i_we, i_waddr, i_wdata   write port
//   i_re, i_raddr            read request, data appears on o_rdata next cycle
//   o_rdata                  registered read data, holds between reads
// ---------------------------------------------------------------------------
module spi_ram_mem #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [7:0]           i_wdata,
    input  logic                 i_re,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [7:0]           o_rdata
);

    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_rdata;

    // Array kept in its own reset-free process so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// spi_ram_ctrl : memory back end for the SPI slave. Accepts one command per
// rising edge of rx_valid, decodes the opcode, keeps write/read address
// registers and returns read bytes on tx_data/tx_valid.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    spi_ram_if.slave (rx_data, rx_valid, tx_data, tx_valid, cmd_err)
// Build option: SPI_RAM_AUTOINC_EN makes wr_addr/rd_addr post-increment
// after each valid data access, wrapping at MEM_DEPTH.
// ---------------------------------------------------------------------------
module spi_ram_ctrl
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    spi_ram_if.slave bus
);

    logic                 r_rx_valid_q;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_waddr_set;
    logic                 r_raddr_set;
    logic                 r_cmd_err;
    tx_state_e            r_state;
    tx_state_e            w_state_nxt;

    logic                 w_accept;
    op_e                  w_op;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_err;

    // Rising edge of the rx_valid level; r_rx_valid_q resets to 1 so a level
    // already high when reset releases is not taken as a command.
    assign w_accept = bus.rx_valid & ~r_rx_valid_q;
    assign w_op     = op_e'(bus.rx_data[CMD_W-1 -: 2]);
    assign w_addr   = bus.rx_data[ADDR_SIZE-1:0];

    assign w_wr_ok  = w_accept && (w_op == OP_WR_DATA) &&  r_waddr_set;
    assign w_rd_ok  = w_accept && (w_op == OP_RD_DATA) &&  r_raddr_set;
    assign w_err    = w_accept && (((w_op == OP_WR_DATA) && !r_waddr_set) ||
                                   ((w_op == OP_RD_DATA) && !r_raddr_set));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_valid_q <= 1'b1;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_waddr_set  <= 1'b0;
            r_raddr_set  <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_rx_valid_q <= bus.rx_valid;
            r_cmd_err    <= w_err;
            if (w_accept && (w_op == OP_WR_ADDR)) begin
                r_wr_addr   <= w_addr;
                r_waddr_set <= 1'b1;
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (w_wr_ok)
                r_wr_addr <= r_wr_addr + 1'b1;   // wraps naturally at 2**ADDR_SIZE
`endif
            if (w_accept && (w_op == OP_RD_ADDR)) begin
                r_rd_addr   <= w_addr;
                r_raddr_set <= 1'b1;
            end
`ifdef SPI_RAM_AUTOINC_EN
            else if (w_rd_ok)
                r_rd_addr <= r_rd_addr + 1'b1;
`endif
        end
    end

    // tx path: HOLD keeps tx_valid up across the slave's shift window until
    // any other command is accepted; a valid read re-enters HOLD with no gap.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= TX_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = w_rd_ok ? TX_HOLD : TX_IDLE;
    end

    // The read register only loads on a valid read, so a later write to the
    // same address leaves an already latched tx_data untouched.
    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_addr),
        .i_wdata (bus.rx_data[7:0]),
        .i_re    (w_rd_ok),
        .i_raddr (r_rd_addr),
        .o_rdata (bus.tx_data)
    );

    assign bus.tx_valid = (r_state == TX_HOLD);
    assign bus.cmd_err  = r_cmd_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_ram_ctrl : self-checking bench for spi_ram_ctrl. Commands come from
// a table of {command, expected outputs} records plus hand-written sequences
// for reset and held-level cases; read data goes through a scoreboard queue.
// Honors SPI_RAM_AUTOINC_EN for the address post-increment expectations.
// ---------------------------------------------------------------------------
module tb_spi_ram_ctrl;
    import spi_pkg::*;

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        logic [9:0] cmd;
        logic       exp_err;
        logic       exp_txv;
        logic [7:0] exp_txd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] sb[$];
    vec_t tab[$];

    spi_ram_if #(.CMD_W(CMD_W)) bus ();

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] c, input logic e, input logic v, input logic [7:0] d);
        vec_t r;
        r.cmd = c; r.exp_err = e; r.exp_txv = v; r.exp_txd = d;
        return r;
    endfunction

    // One rx_valid pulse, checks on the cycle after acceptance and one later.
    task automatic send(input vec_t v);
        logic is_rd;
        is_rd = (v.cmd[9:8] == 2'b11);
        @(negedge clk);
        bus.rx_data  = v.cmd;
        bus.rx_valid = 1'b1;
        if (is_rd && v.exp_txv) sb.push_back(v.exp_txd);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk($sformatf("cmd_err[%03h]", v.cmd), 8'(bus.cmd_err), 8'(v.exp_err));
        chk($sformatf("tx_valid[%03h]", v.cmd), 8'(bus.tx_valid), 8'(v.exp_txv));
        if (is_rd && bus.tx_valid) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL tx_data[%03h]: got %0h want no output", v.cmd, bus.tx_data);
            end else begin
                chk($sformatf("tx_data[%03h]", v.cmd), bus.tx_data, sb.pop_front());
            end
        end else begin
            chk($sformatf("tx_hold[%03h]", v.cmd), bus.tx_data, v.exp_txd);
        end
        @(negedge clk);
        chk($sformatf("err_pulse[%03h]", v.cmd), 8'(bus.cmd_err), 8'd0);
        chk($sformatf("txv_keep[%03h]", v.cmd), 8'(bus.tx_valid), 8'(v.exp_txv));
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_txv"}, 8'(bus.tx_valid), 8'd0);
        chk({nm, "_txd"}, bus.tx_data, 8'd0);
        chk({nm, "_err"}, 8'(bus.cmd_err), 8'd0);
    endtask

    initial begin
        logic [7:0] d2;
        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_idle("reset");

        // Main table: address/data round trips, tx_valid clear and no-gap reads,
        // and the write-after-latch collision.
        d2 = AUTO ? 8'h5A : 8'h3C;
        tab.push_back(mk(10'h0A5, 0, 0, 8'h00));
        tab.push_back(mk(10'h13C, 0, 0, 8'h00));
        tab.push_back(mk(10'h0A6, 0, 0, 8'h00));
        tab.push_back(mk(10'h15A, 0, 0, 8'h00));
        tab.push_back(mk(10'h2A5, 0, 0, 8'h00));
        tab.push_back(mk(10'h300, 0, 1, 8'h3C));
        tab.push_back(mk(10'h010, 0, 0, 8'h3C));
        tab.push_back(mk(10'h2A5, 0, 0, 8'h3C));
        tab.push_back(mk(10'h300, 0, 1, 8'h3C));
        tab.push_back(mk(10'h300, 0, 1, d2));
        tab.push_back(mk(10'h207, 0, 0, d2));
        tab.push_back(mk(10'h007, 0, 0, d2));
        tab.push_back(mk(10'h155, 0, 0, d2));
        tab.push_back(mk(10'h300, 0, 1, 8'h55));
        tab.push_back(mk(10'h007, 0, 0, 8'h55));
        tab.push_back(mk(10'h1AA, 0, 0, 8'h55));
        tab.push_back(mk(10'h207, 0, 0, 8'h55));
        tab.push_back(mk(10'h300, 0, 1, 8'hAA));
        foreach (tab[i]) send(tab[i]);

        // Held level: one accept only; data changing under the held level is ignored.
        @(negedge clk);
        bus.rx_data  = 10'h0A5;
        bus.rx_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.rx_data = 10'h177;
            chk("hold_err", 8'(bus.cmd_err), 8'd0);
            chk("hold_txv", 8'(bus.tx_valid), 8'd0);
        end
        bus.rx_valid = 1'b0;
        send(mk(10'h2A5, 0, 0, 8'hAA));
        send(mk(10'h300, 0, 1, 8'h3C));
        send(mk(10'h13C, 0, 0, 8'h3C));
        send(mk(10'h2A5, 0, 0, 8'h3C));
        send(mk(10'h300, 0, 1, 8'h3C));

        // Order violations after reset; RAM left untouched by the refused write.
        send(mk(10'h0FF, 0, 0, 8'h3C));
        send(mk(10'h1EE, 0, 0, 8'h3C));
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk_idle("reset2");
        send(mk(10'h300, 1, 0, 8'h00));
        send(mk(10'h1FF, 1, 0, 8'h00));
        send(mk(10'h2FF, 0, 0, 8'h00));
        send(mk(10'h300, 0, 1, 8'hEE));

        // Mid-operation reset while tx_valid is high, with rx_valid held high
        // across reset release so that command must not be taken.
        chk("pre_rst_txv", 8'(bus.tx_valid), 8'd1);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.rx_data  = 10'h2A5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk_idle("reset3");
        repeat (3) begin
            @(negedge clk);
            chk("rel_txv", 8'(bus.tx_valid), 8'd0);
            chk("rel_err", 8'(bus.cmd_err), 8'd0);
        end
        bus.rx_valid = 1'b0;
        send(mk(10'h300, 1, 0, 8'h00));

        // Burst across the top address (wraps only with post-increment).
        send(mk(10'h0FF, 0, 0, 8'h00));
        send(mk(10'h111, 0, 0, 8'h00));
        send(mk(10'h122, 0, 0, 8'h00));
        send(mk(10'h2FF, 0, 0, 8'h00));
        send(mk(10'h300, 0, 1, AUTO ? 8'h11 : 8'h22));
        send(mk(10'h300, 0, 1, 8'h22));

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
